unstripe_lane_sched: RTL
========================

// Module: unstripe_lane_sched
// PURPOSE
//  Receive-side unstripe scheduler for the two-lane PHY. Buffers per-lane bytes from the
//  serial-to-parallel stages and merges them back into one byte stream in strict stripe
//  order (lane0, lane1, lane0, ...). Output feeds the unstripe output flop stage on clk_2f.
//  It absorbs small inter-lane skew, stalls on a missing byte and flags overflow and skew.
// PARAMETERS
//  DATA_WIDTH   8  byte width per lane and on the output
//  FIFO_DEPTH   4  entries per lane buffer; power of two, >=2
// PORTS
//  clk_2f       in   1           single clock; all logic on its rising edge
//  reset        in   1           synchronous, active-low; 0 = reset
//  flush        in   1           sync flush of buffers and sequencer; error flags kept
//  data_in0     in   DATA_WIDTH  lane0 byte
//  valid_in0    in   1           lane0 byte valid; push into lane0 buffer
//  data_in1     in   DATA_WIDTH  lane1 byte
//  valid_in1    in   1           lane1 byte valid; push into lane1 buffer
//  data_out0    out  DATA_WIDTH  merged byte, registered
//  valid_out    out  1           data_out0 valid this cycle, registered
//  lane_sel     out  1           lane expected next (0/1)
//  active       out  1           1 in RUN state
//  ovf_err      out  2           sticky per-lane overflow, bit i = lane i
//  skew_err     out  1           sticky skew flag
// BEHAVIOUR
//  Reset (reset==0 at edge): data_out0=0, valid_out=0, lane_sel=0, active=0, ovf_err=0,
//   skew_err=0, both buffers empty, state IDLE. Reset overrides flush and all pushes.
//  Push: valid_inN=1 at edge -> byte written to lane N buffer. Full and no pop that cycle
//   -> byte dropped, ovf_err[N]<=1. Full with a pop from the same buffer -> accepted.
//  FSM: IDLE -> RUN on first pop. RUN -> IDLE only on flush or reset.
//  Pop, each edge: buffer[lane_sel] non-empty -> pop head, data_out0<=head, valid_out<=1,
//   lane_sel toggles. Empty -> valid_out<=0, data_out0 holds, lane_sel holds (stall).
//   Never skip a lane; lane1 bytes are never output before the preceding lane0 byte.
//  Latency: byte presented at edge k into empty expected buffer -> valid_out=1 after k+1.
//   No bypass path. Sustained rate: 1 byte/cycle when both lanes supply 1 byte per 2 cycles.
//  Simultaneous push+pop on one buffer: occupancy unchanged, head order preserved.
//  Pointer wrap: read/write pointers wrap modulo FIFO_DEPTH. Occupancy is counted to
//   FIFO_DEPTH inclusive, so full and empty are distinguished.
//  skew_err<=1 when buffer[lane_sel] empty AND the other buffer full at the same edge.
//  flush=1 at edge: both buffers emptied, lane_sel=0, state IDLE, active=0, valid_out=0.
//   data_out0 holds. ovf_err/skew_err kept. Pushes in the flush cycle are discarded.
//  active = (state==RUN), registered with the state.
// STRUCTURE
//  Package phy_pkg: DATA_WIDTH default, lane index typedef (1 bit), FSM state enum
//   {IDLE, RUN}, LANE0/LANE1 constants.
//  Sub-module unstripe_lane_fifo (x2): sync FIFO, DATA_WIDTH x FIFO_DEPTH, with push/pop/
//   clr, head data, empty/full. It drops pushes when full without a pop.
//  Top: two FIFO instances, the lane_sel/FSM register, error flags and the output register.
// TESTING
//  1 reset=0 for 2 cycles mid-stream with lanes busy -> all outputs 0, then out restarts
//    from lane0. No stale byte appears.
//  2 in0=A0,in1=B0 same cycle, next in0=A1,in1=B1 -> data_out0 A0,B0,A1,B1 on 4
//    consecutive cycles. valid_out stays 1 and lane_sel follows 1,0,1,0.
//  3 in0=11 at cycle0, in1=22 at cycle3 -> 11 out after edge1, then valid_out=0 and
//    lane_sel=1 held until 22 out after edge4.
//  4 only lane1 pushes 01..05 on 5 cycles -> 05 dropped and ovf_err=2'b10. skew_err=1
//    once lane1 is full, with valid_out=0 throughout.
//  5 after test 4, in0=AA -> out AA,01,02,03,04. Errors stay set.
//  6 flush with 2 bytes buffered per lane -> valid_out=0 next cycle and active=0. Errors
//    kept. The next in0=5A/in1=5B pair is output as 5A,5B.

Source files
------------

// File: rtl/phy_pkg.sv
// Shared definitions for the two-lane PHY receive path.
//   PHY_DATA_WIDTH : default byte width per lane
//   lane_t         : lane index (1 bit), with LANE0 / LANE1 constants
//   state_t        : unstripe sequencer state {IDLE, RUN}
package phy_pkg;
    localparam int PHY_DATA_WIDTH = 8;

    typedef logic lane_t;

    localparam lane_t LANE0 = 1'b0;
    localparam lane_t LANE1 = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/unstripe_lane_fifo.sv
// Per-lane synchronous FIFO for the unstripe scheduler.
//   clk_2f, reset (sync, active-low), clr (sync empty)
//   push/din : write side. A push into a full buffer is accepted only when
//              the same cycle also pops; otherwise it is dropped and 'drop' pulses.
//   pop      : remove head (ignored when empty)
//   head     : current head byte (combinational from storage, no bypass)
//   empty/full : occupancy status, from a count that reaches FIFO_DEPTH
module unstripe_lane_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_2f,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  empty,
    output logic                  full,
    output logic                  drop
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         rptr, wptr;
    logic [CW-1:0]         count;
    logic                  accept, do_pop;

    assign empty  = (count == '0);
    assign full   = (count == CW'(FIFO_DEPTH));
    assign do_pop = pop && !empty;
    // When full, the slot being written is the one being read this edge.
    assign accept = push && (!full || do_pop);
    assign drop   = push && full && !do_pop;
    assign head   = mem[rptr];

    // Pointers wrap naturally since FIFO_DEPTH is a power of two.
    always_ff @(posedge clk_2f) begin
        if (!reset || clr) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (accept) wptr <= wptr + AW'(1);
            if (do_pop) rptr <= rptr + AW'(1);
            case ({accept, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_2f) begin
        if (reset && !clr && accept) mem[wptr] <= din;
    end
endmodule

// File: rtl/unstripe_lane_sched.sv
// Receive-side unstripe scheduler: merges two lane buffers back into one byte
// stream in strict lane0, lane1, lane0 ... order, stalling on a missing byte.
//   clk_2f, reset (sync, active-low), flush (sync, keeps error flags)
//   data_in0/valid_in0, data_in1/valid_in1 : per-lane byte pushes
//   data_out0/valid_out : registered merged byte
//   lane_sel : lane expected next; active : sequencer in RUN
//   ovf_err[i] : sticky lane-i overflow; skew_err : sticky skew flag
module unstripe_lane_sched
    import phy_pkg::*;
#(
    parameter int DATA_WIDTH = PHY_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_2f,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] data_in0,
    input  logic                  valid_in0,
    input  logic [DATA_WIDTH-1:0] data_in1,
    input  logic                  valid_in1,
    output logic [DATA_WIDTH-1:0] data_out0,
    output logic                  valid_out,
    output lane_t                 lane_sel,
    output logic                  active,
    output logic [1:0]            ovf_err,
    output logic                  skew_err
);
    logic [DATA_WIDTH-1:0] head0, head1, head_sel;
    logic [1:0]            empty, full, drop, pop;
    logic                  pop_req;
    state_t                state, state_n;
    lane_t                 lane_sel_n;

    // Flush discards the cycle's pushes and suppresses the pop.
    assign pop_req  = !flush && !empty[lane_sel];
    assign pop[0]   = pop_req && (lane_sel == LANE0);
    assign pop[1]   = pop_req && (lane_sel == LANE1);
    assign head_sel = (lane_sel == LANE0) ? head0 : head1;

    unstripe_lane_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk_2f(clk_2f), .reset(reset), .clr(flush),
        .push(valid_in0 && !flush), .din(data_in0), .pop(pop[0]),
        .head(head0), .empty(empty[0]), .full(full[0]), .drop(drop[0])
    );

    unstripe_lane_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk_2f(clk_2f), .reset(reset), .clr(flush),
        .push(valid_in1 && !flush), .din(data_in1), .pop(pop[1]),
        .head(head1), .empty(empty[1]), .full(full[1]), .drop(drop[1])
    );

    always_ff @(posedge clk_2f) begin
        if (!reset) begin
            state    <= IDLE;
            lane_sel <= LANE0;
        end else begin
            state    <= state_n;
            lane_sel <= lane_sel_n;
        end
    end

    always_comb begin
        state_n    = state;
        lane_sel_n = lane_sel;
        if (flush) begin
            state_n    = IDLE;
            lane_sel_n = LANE0;
        end else if (pop_req) begin
            state_n    = RUN;
            lane_sel_n = ~lane_sel;
        end
    end

    assign active = (state == RUN);

    always_ff @(posedge clk_2f) begin
        if (!reset) begin
            data_out0 <= '0;
            valid_out <= 1'b0;
        end else if (pop_req) begin
            data_out0 <= head_sel;
            valid_out <= 1'b1;
        end else begin
            valid_out <= 1'b0;
        end
    end

    // Skew: the expected lane has nothing while the other lane has run out of room.
    always_ff @(posedge clk_2f) begin
        if (!reset) begin
            ovf_err  <= 2'b00;
            skew_err <= 1'b0;
        end else begin
            ovf_err <= ovf_err | drop;
            if (!flush && empty[lane_sel] && full[~lane_sel]) skew_err <= 1'b1;
        end
    end
endmodule
